// File: rtl/led_pio_write_arbiter.sv
// Round-robin arbiter that serialises requester LED patterns into zero-wait PIO writes.
// Define LED_ARB_READBACK_EN to verify every write with a readback and a sticky mismatch flag.
module led_pio_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic [2:0]         owner,
    output logic [1:0]         m_address,
    output logic               m_chipselect,
    output logic               m_write_n,
    output logic [31:0]        m_writedata,
    input  logic [31:0]        m_readdata
`ifdef LED_ARB_READBACK_EN
    ,
    input  logic               clear_mismatch,
    output logic               mismatch
`endif
);

    // state | meaning
    // IDLE  | waiting for a request; winner and its pattern are latched on exit
    // WRITE | write strobe and grant pulse on the PIO port
    // READ  | readback of address 0, compared against the latched pattern
`ifdef LED_ARB_READBACK_EN
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    logic [DW-1:0] data_q;
`else
    typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

    state_t        state;
    logic [2:0]    ptr;
    logic [NREQ-1:0] req_rot;
    logic [2:0]    win_idx;
    logic [DW-1:0] win_data;
    logic          unused_readdata;

    assign m_address       = 2'b00;
    assign unused_readdata = ^m_readdata;

    // Rotating by ptr turns the round-robin search into a fixed lowest-index search.
    assign req_rot = NREQ'({req, req} >> ptr);

    always_comb begin
        int win_off;
        int win_sum;
        win_off = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) win_off = k;
        end
        win_sum = int'(ptr) + win_off;
        win_idx = (win_sum >= NREQ) ? 3'(win_sum - NREQ) : 3'(win_sum);
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 3'(i)) win_data = req_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            owner        <= '0;
            grant        <= '0;
            busy         <= 1'b0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
`ifdef LED_ARB_READBACK_EN
            data_q       <= '0;
            mismatch     <= 1'b0;
`endif
        end else begin
            grant        <= '0;
            busy         <= 1'b0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
`ifdef LED_ARB_READBACK_EN
            if (clear_mismatch) mismatch <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        state        <= WRITE;
                        busy         <= 1'b1;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_writedata  <= 32'(win_data);
                        grant        <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        owner        <= win_idx;
                        ptr          <= (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
`ifdef LED_ARB_READBACK_EN
                        data_q       <= win_data;
`endif
                    end
                end
                WRITE: begin
`ifdef LED_ARB_READBACK_EN
                    state        <= READ;
                    busy         <= 1'b1;
                    m_chipselect <= 1'b1;
`else
                    state        <= IDLE;
`endif
                end
`ifdef LED_ARB_READBACK_EN
                READ: begin
                    state <= IDLE;
                    // Placed after the clear so a failing compare wins over clear_mismatch.
                    if (m_readdata[DW-1:0] != data_q) mismatch <= 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// Scoreboard bench for led_pio_write_arbiter with a PIO register model.
// Honours LED_ARB_READBACK_EN the same way as the design.
module tb_led_pio_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 9;
`ifdef LED_ARB_READBACK_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 2;
`endif

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [2:0]         owner;
    logic [1:0]         m_address;
    logic               m_chipselect;
    logic               m_write_n;
    logic [31:0]        m_writedata;
    logic [31:0]        m_readdata;
`ifdef LED_ARB_READBACK_EN
    logic               clear_mismatch = 1'b0;
    logic               mismatch;
`endif

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            model_ptr = 0;
    int            cyc = 0;
    logic [DW-1:0] pio_out;
    logic          stuck0 = 1'b0;

    led_pio_write_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_data       (req_data),
        .grant          (grant),
        .busy           (busy),
        .owner          (owner),
        .m_address      (m_address),
        .m_chipselect   (m_chipselect),
        .m_write_n      (m_write_n),
        .m_writedata    (m_writedata),
        .m_readdata     (m_readdata)
`ifdef LED_ARB_READBACK_EN
        ,
        .clear_mismatch (clear_mismatch),
        .mismatch       (mismatch)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave: 9-bit output register at address 0, optional stuck-at-0 on bit 0 of the read path.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pio_out <= '0;
        else if (m_chipselect && !m_write_n && m_address == 2'd0) pio_out <= m_writedata[DW-1:0];
    end
    assign m_readdata = 32'(pio_out) & ~32'(stuck0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g);
        g = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                g = grant;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL grant_timeout actual=none expected=grant within 40 cycles");
    endtask

    // Reference round-robin: first requester at or after model_ptr, modulo NREQ.
    task automatic predict();
        int w;
        int i;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (model_ptr + k) % NREQ;
            if (w < 0 && req[i]) w = i;
        end
        exp_q.push_back('{w, req_data[w*DW +: DW]});
        model_ptr = (w + 1) % NREQ;
    endtask

    // Monitor: every write strobe pops one expectation.
    initial begin
        exp_t          e;
        logic          pio_pend;
        logic [DW-1:0] pio_exp;
        int            own_exp;
        pio_pend = 1'b0;
        pio_exp  = '0;
        own_exp  = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pio_pend = 1'b0;
            end else begin
                if (pio_pend) begin
                    check("pio_out", 32'(pio_out), 32'(pio_exp));
                    check("owner", 32'(owner), 32'(own_exp));
                    pio_pend = 1'b0;
                end
                if (m_chipselect && !m_write_n) begin
                    check("write_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("grant", 32'(grant), 32'(1 << e.idx));
                        check("writedata", m_writedata, 32'(e.data));
                        check("address", 32'(m_address), 32'd0);
                        check("busy_write", 32'(busy), 32'd1);
                        pio_pend = 1'b1;
                        pio_exp  = e.data;
                        own_exp  = e.idx;
                    end
                end else if (grant != '0) begin
                    check("grant_without_write", 32'(grant), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] g;
        int prev;
        int grants;
        int stall;
        int w;

        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_cs", 32'(m_chipselect), 32'd0);
        check("rst_write_n", 32'(m_write_n), 32'd1);
        check("rst_writedata", m_writedata, 32'd0);
`ifdef LED_ARB_READBACK_EN
        check("rst_mismatch", 32'(mismatch), 32'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);

        // Single request: strobe one cycle after req, grant in the same cycle.
        req_data[0 +: DW] = 9'h155;
        req = 4'b0001;
        exp_q.push_back('{0, 9'h155});
        model_ptr = 1;
        @(negedge clk);
        check("single_strobe", {30'd0, m_chipselect, m_write_n}, 32'b10);
        check("single_grant", 32'(grant), 32'b0001);
        check("single_data", m_writedata, 32'h155);
        req = '0;
        repeat (3) @(negedge clk);
        check("single_pio", 32'(pio_out), 32'h155);
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_idle_cs", 32'(m_chipselect), 32'd0);

        // Reset in the WRITE cycle: no grant, pointer back to 0.
        req_data[2*DW +: DW] = 9'h0AA;
        req = 4'b0100;
        @(posedge clk);
        #1 reset_n = 1'b0;
        req = '0;
        @(negedge clk);
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_cs", 32'(m_chipselect), 32'd0);
        check("abort_write_n", 32'(m_write_n), 32'd1);
        check("abort_writedata", m_writedata, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_owner", 32'(owner), 32'd0);
        check("abort_pio", 32'(pio_out), 32'd0);
        reset_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);

        // All four requesting: order 0,1,2,3,0 at one grant per GAP cycles.
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'(9'h100 + i);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) exp_q.push_back('{n % NREQ, DW'(9'h100 + (n % NREQ))});
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_grant(g);
            if (n > 0) check("cont_gap", 32'(cyc - prev), 32'(GAP));
            prev = cyc;
            if (n == 4) req = '0;
        end
        model_ptr = 1;
        repeat (3) @(negedge clk);

        // Pointer wrap: grant 3, then 1010 gives 1 before 3.
        req_data[3*DW +: DW] = 9'h033;
        req = 4'b1000;
        exp_q.push_back('{3, 9'h033});
        wait_grant(g);
        req = '0;
        repeat (2) @(negedge clk);
        req_data[1*DW +: DW] = 9'h011;
        req_data[3*DW +: DW] = 9'h1EE;
        req = 4'b1010;
        exp_q.push_back('{1, 9'h011});
        exp_q.push_back('{3, 9'h1EE});
        wait_grant(g);
        check("wrap_first", 32'(g), 32'b0010);
        req[1] = 1'b0;
        wait_grant(g);
        check("wrap_second", 32'(g), 32'b1000);
        req = '0;
        model_ptr = 0;
        repeat (3) @(negedge clk);

        // Request held for exactly one cycle still completes.
        req_data[2*DW +: DW] = 9'h0C3;
        req = 4'b0100;
        exp_q.push_back('{2, 9'h0C3});
        @(negedge clk);
        req = '0;
        check("drop_grant", 32'(grant), 32'b0100);
        model_ptr = 3;
        repeat (4) @(negedge clk);
        check("drop_drained", 32'(exp_q.size()), 32'd0);

`ifdef LED_ARB_READBACK_EN
        // Readback with bit 0 stuck at 0 on the read path.
        stuck0 = 1'b1;
        req_data[0 +: DW] = 9'h001;
        req = 4'b0001;
        exp_q.push_back('{0, 9'h001});
        wait_grant(g);
        req = '0;
        @(negedge clk);
        check("rb_before_compare", 32'(mismatch), 32'd0);
        @(negedge clk);
        check("rb_mismatch_set", 32'(mismatch), 32'd1);
        repeat (3) @(negedge clk);
        check("rb_mismatch_sticky", 32'(mismatch), 32'd1);
        req_data[1*DW +: DW] = 9'h0FF;
        req = 4'b0010;
        exp_q.push_back('{1, 9'h0FF});
        wait_grant(g);
        req = '0;
        @(negedge clk);
        clear_mismatch = 1'b1;
        @(negedge clk);
        clear_mismatch = 1'b0;
        check("rb_set_wins", 32'(mismatch), 32'd1);
        @(negedge clk);
        clear_mismatch = 1'b1;
        @(negedge clk);
        clear_mismatch = 1'b0;
        check("rb_clear", 32'(mismatch), 32'd0);
        stuck0 = 1'b0;
        model_ptr = 2;
        repeat (2) @(negedge clk);
`endif

        // Random traffic: req changes only in a grant cycle or while nothing is requested.
        grants = 0;
        stall = 0;
        for (int c = 0; c < 6000 && grants < 300; c++) begin
            @(negedge clk);
            if (grant != '0) begin
                stall = 0;
                grants++;
                w = 0;
                for (int i = 0; i < NREQ; i++) if (grant[i]) w = i;
                if (grants >= 300) begin
                    req = '0;
                end else begin
                    if ($urandom_range(1, 0) == 1) req_data[w*DW +: DW] = DW'($urandom);
                    else req[w] = 1'b0;
                    for (int i = 0; i < NREQ; i++) begin
                        if (!req[i] && i != w && $urandom_range(3, 0) == 0) begin
                            req_data[i*DW +: DW] = DW'($urandom);
                            req[i] = 1'b1;
                        end
                    end
                    if (req != '0) predict();
                end
            end else if (req == '0) begin
                if ($urandom_range(2, 0) == 0) begin
                    for (int i = 0; i < NREQ; i++) begin
                        req_data[i*DW +: DW] = DW'($urandom);
                        req[i] = ($urandom_range(1, 0) == 1);
                    end
                    if (req == '0) req[$urandom_range(NREQ-1, 0)] = 1'b1;
                    predict();
                end
            end else begin
                stall++;
                if (stall > 12) begin
                    checks++;
                    failures++;
                    $display("FAIL random_stall actual=no grant for %0d cycles expected=grant", stall);
                    break;
                end
            end
        end
        check("random_grants", 32'(grants), 32'd300);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);
`ifdef LED_ARB_READBACK_EN
        check("final_mismatch", 32'(mismatch), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
